// File: rtl/deep_sump_capture_ctrl_pkg.sv
// deep_sump_capture_ctrl_pkg: shared state encoding and packing order for the Deep Sump capture path
package deep_sump_capture_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;
  // First sample of a word lands in the high DWORD, matching HyperRAM DWORD-1 first.
  localparam logic PACK_FIRST_HI = 1'b1;
endpackage

// File: rtl/deep_sump_capture_ctrl_if.sv
// deep_sump_capture_ctrl_if: write port and overrun flag between the capture sequencer and deep memory
interface deep_sump_capture_ctrl_if #(parameter int depth_bits = 16);
  logic                  a_we;
  logic [depth_bits-1:0] a_addr;
  logic [63:0]           a_di;
  logic                  a_overrun;
  modport master (output a_we, a_addr, a_di, input a_overrun);
  modport slave  (input a_we, a_addr, a_di, output a_overrun);
endinterface

// File: rtl/deep_sump_capture_ctrl_packer.sv
// deep_sump_capture_ctrl_packer: packs 32-bit samples into 64-bit words and strobes each completed word
module deep_sump_capture_ctrl_packer
  import deep_sump_capture_ctrl_pkg::*;
(
  input  logic        a_clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic [31:0] sample_d,
  output logic        fire,
  output logic        we_q,
  output logic [63:0] di_q
);
  logic        phase_q, phase_d, we_d, lo;
  logic [63:0] di_d;
  assign fire = en & phase_q;
  assign lo   = phase_q ^ ~PACK_FIRST_HI;
  // next phase, word strobe and the half of the word this sample fills
  always_comb begin
    phase_d = clear ? 1'b0 : phase_q ^ en;
    we_d    = fire;
    di_d    = !en ? di_q : lo ? {di_q[63:32], sample_d} : {sample_d, di_q[31:0]};
  end
  // packing registers
  always_ff @(posedge a_clk) begin
    if (reset) begin
      phase_q <= 1'b0;
      we_q    <= 1'b0;
      di_q    <= '0;
    end else begin
      phase_q <= phase_d;
      we_q    <= we_d;
      di_q    <= di_d;
    end
  end
endmodule

// File: rtl/deep_sump_capture_ctrl.sv
// deep_sump_capture_ctrl: arm/trigger/post-trigger sequencer writing packed samples into a circular buffer
module deep_sump_capture_ctrl
  import deep_sump_capture_ctrl_pkg::*;
#(
  parameter int depth_bits = 16
) (
  input  logic                  a_clk,
  input  logic                  reset,
  input  logic                  arm,
  input  logic [depth_bits-1:0] post_trig_len,
  input  logic                  sample_en,
  input  logic [31:0]           sample_d,
  input  logic                  trigger,
  deep_sump_capture_ctrl_if.master mem,
  output logic                  armed,
  output logic                  triggered,
  output logic                  done,
  output logic                  wrapped,
  output logic                  overrun_err,
  output logic [depth_bits-1:0] trig_ptr
);
  typedef logic [depth_bits-1:0] ptr_t;
  state_e state_q, state_d;
  ptr_t   wr_ptr_q, wr_ptr_d, post_cnt_q, post_cnt_d, len_q, len_d;
  ptr_t   trig_ptr_q, trig_ptr_d, a_addr_q, a_addr_d, cnt_cur;
  logic   armed_q, armed_d, triggered_q, triggered_d, done_q, done_d;
  logic   wrapped_q, wrapped_d, overrun_q, overrun_d;
  logic   capturing, en, fire, trig_hit, in_post;
  logic   we_q;
  logic [63:0] di_q;
  // arm beats any coincident sample, so that sample never reaches the packer
  assign capturing = (state_q == ST_ARMED) || (state_q == ST_POST);
  assign en        = sample_en & capturing & ~arm;
  assign trig_hit  = en & trigger & (state_q == ST_ARMED);
  // a trigger sample already counts as the post phase, with the current word as count 0
  assign in_post   = trig_hit | (state_q == ST_POST);
  assign cnt_cur   = (state_q == ST_POST) ? post_cnt_q : '0;
  deep_sump_capture_ctrl_packer u_packer (
    .a_clk    (a_clk),
    .reset    (reset),
    .clear    (arm),
    .en       (en),
    .sample_d (sample_d),
    .fire     (fire),
    .we_q     (we_q),
    .di_q     (di_q)
  );
  assign mem.a_we    = we_q;
  assign mem.a_di    = di_q;
  assign mem.a_addr  = a_addr_q;
  assign armed       = armed_q;
  assign triggered   = triggered_q;
  assign done        = done_q;
  assign wrapped     = wrapped_q;
  assign overrun_err = overrun_q;
  assign trig_ptr    = trig_ptr_q;
  // sequencing, pointers and sticky flags; arm restarts everything
  always_comb begin
    state_d     = arm ? ST_ARMED
                : (in_post & fire) ? ((cnt_cur == len_q) ? ST_DONE : ST_POST)
                : trig_hit ? ST_POST : state_q;
    post_cnt_d  = arm ? '0 : (in_post & fire) ? cnt_cur + ptr_t'(1) : trig_hit ? '0 : post_cnt_q;
    len_d       = arm ? post_trig_len : len_q;
    wr_ptr_d    = arm ? '0 : fire ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
    wrapped_d   = ~arm & (wrapped_q | (fire & (&wr_ptr_q)));
    overrun_d   = ~arm & (overrun_q | (mem.a_overrun & capturing));
    trig_ptr_d  = arm ? '0 : trig_hit ? wr_ptr_q : trig_ptr_q;
    a_addr_d    = fire ? wr_ptr_q : a_addr_q;
    armed_d     = state_d == ST_ARMED;
    triggered_d = (state_d == ST_POST) || (state_d == ST_DONE);
    done_d      = state_d == ST_DONE;
  end
  // state and registered outputs
  always_ff @(posedge a_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      post_cnt_q  <= '0;
      len_q       <= '0;
      wr_ptr_q    <= '0;
      wrapped_q   <= 1'b0;
      overrun_q   <= 1'b0;
      trig_ptr_q  <= '0;
      a_addr_q    <= '0;
      armed_q     <= 1'b0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      post_cnt_q  <= post_cnt_d;
      len_q       <= len_d;
      wr_ptr_q    <= wr_ptr_d;
      wrapped_q   <= wrapped_d;
      overrun_q   <= overrun_d;
      trig_ptr_q  <= trig_ptr_d;
      a_addr_q    <= a_addr_d;
      armed_q     <= armed_d;
      triggered_q <= triggered_d;
      done_q      <= done_d;
    end
  end
endmodule

// File: tb/tb_deep_sump_capture_ctrl.sv
// tb_deep_sump_capture_ctrl: directed and random checks against a sample-count reference model
module tb_deep_sump_capture_ctrl;
  localparam int D = 16;
  logic        a_clk = 1'b0;
  logic        reset = 1'b1;
  logic        arm = 1'b0;
  logic        sample_en = 1'b0;
  logic        trigger = 1'b0;
  logic [31:0] sample_d = '0;
  logic [3:0]  len = '0;
  logic        armed, triggered, done, wrapped, overrun_err;
  logic [3:0]  trig_ptr;
  int vectors = 0;
  int miscompares = 0;

  deep_sump_capture_ctrl_if #(.depth_bits(4)) mem ();

  deep_sump_capture_ctrl #(.depth_bits(4)) dut (
    .a_clk         (a_clk),
    .reset         (reset),
    .arm           (arm),
    .post_trig_len (len),
    .sample_en     (sample_en),
    .sample_d      (sample_d),
    .trigger       (trigger),
    .mem           (mem),
    .armed         (armed),
    .triggered     (triggered),
    .done          (done),
    .wrapped       (wrapped),
    .overrun_err   (overrun_err),
    .trig_ptr      (trig_ptr)
  );

  always #5 a_clk = ~a_clk;

  // reference model: samples accepted since arm, absolute trigger word, words written
  logic        m_cap = 1'b0, m_done = 1'b0, m_ovr = 1'b0, m_we = 1'b0;
  int          m_n = 0, m_trig = -1, m_words = 0;
  logic [3:0]  m_len = '0, m_addr = '0;
  logic [31:0] m_hi = '0;
  logic [63:0] m_di = '0;

  function automatic logic [77:0] obs();
    return {mem.a_we, mem.a_we ? mem.a_addr : 4'h0, mem.a_we ? mem.a_di : 64'h0,
            armed, triggered, done, wrapped, overrun_err, trig_ptr};
  endfunction

  function automatic logic [77:0] expv();
    return {m_we, m_we ? m_addr : 4'h0, m_we ? m_di : 64'h0,
            m_cap && m_trig < 0, m_trig >= 0, m_done, m_words >= D, m_ovr,
            m_trig >= 0 ? 4'(m_trig % D) : 4'h0};
  endfunction

  task automatic step(input logic a, input logic e, input logic [31:0] d, input logic t, input logic o);
    arm = a; sample_en = e; sample_d = d; trigger = t; mem.a_overrun = o;
    @(posedge a_clk);
    m_we = 1'b0;
    if (a) begin
      m_cap = 1'b1; m_n = 0; m_trig = -1; m_len = len; m_done = 1'b0; m_ovr = 1'b0; m_words = 0;
    end else if (m_cap) begin
      if (o) m_ovr = 1'b1;
      if (e) begin
        if (t && m_trig < 0) m_trig = m_n / 2;
        if (m_n % 2 == 0) m_hi = d;
        else begin
          m_we = 1'b1; m_addr = 4'((m_n / 2) % D); m_di = {m_hi, d}; m_words++;
          if (m_trig >= 0 && m_n / 2 == m_trig + int'(m_len)) begin m_done = 1'b1; m_cap = 1'b0; end
        end
        m_n++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; arm = 1'b0; sample_en = 1'b0; trigger = 1'b0; mem.a_overrun = 1'b0;
    repeat (2) @(posedge a_clk);
    #1;
    reset = 1'b0;
    m_cap = 1'b0; m_done = 1'b0; m_ovr = 1'b0; m_we = 1'b0; m_n = 0; m_trig = -1; m_words = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({obs(), mem.a_addr, mem.a_di} !== '0) begin
      miscompares++;
      $display("FAIL reset_values got %h addr %h di %h expected all zero", obs(), mem.a_addr, mem.a_di);
    end
  endtask

  task automatic test_pack_order();
    len = 4'd15;
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    vectors++; if (obs() !== expv()) begin miscompares++; $display("FAIL pack_arm got %h exp %h", obs(), expv()); end
    step(1'b0, 1'b1, 32'h11111111, 1'b0, 1'b0);
    vectors++; if (mem.a_we !== 1'b0) begin miscompares++; $display("FAIL pack_early_we got %b exp 0", mem.a_we); end
    step(1'b0, 1'b1, 32'h22222222, 1'b0, 1'b0);
    vectors++;
    if ({mem.a_we, mem.a_addr, mem.a_di} !== {1'b1, 4'h0, 64'h1111111122222222}) begin
      miscompares++;
      $display("FAIL pack_word got we=%b addr=%h di=%h exp we=1 addr=0 di=1111111122222222", mem.a_we, mem.a_addr, mem.a_di);
    end
    vectors++; if (obs() !== expv()) begin miscompares++; $display("FAIL pack_model got %h exp %h", obs(), expv()); end
  endtask

  task automatic test_wrap();
    int writes = 0;
    logic [3:0] last = '0;
    len = 4'd7;
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, $urandom, 1'b0, 1'b0);
      vectors++; if (obs() !== expv()) begin miscompares++; $display("FAIL wrap_model i=%0d got %h exp %h", i, obs(), expv()); end
      if (mem.a_we === 1'b1) begin
        writes++; last = mem.a_addr;
        if (writes == 16) begin
          vectors++; if (wrapped !== 1'b1) begin miscompares++; $display("FAIL wrap_flag got %b exp 1", wrapped); end
        end
      end
    end
    vectors++;
    if (writes != 20 || last !== 4'd3 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_summary got writes=%0d last=%0d done=%b exp 20 3 0", writes, last, done);
    end
  endtask

  task automatic test_post_trigger();
    int nw = 0, done_addr = -1;
    logic [3:0] last = '0;
    len = 4'd3;
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 1'b1, $urandom, i == 7, 1'b0);
      vectors++; if (obs() !== expv()) begin miscompares++; $display("FAIL post_model i=%0d got %h exp %h", i, obs(), expv()); end
      if (mem.a_we === 1'b1) begin
        nw++; last = mem.a_addr;
        if (done === 1'b1) done_addr = int'(mem.a_addr);
      end
    end
    vectors++;
    if (trig_ptr !== 4'd3 || last !== 4'd6 || done_addr != 6 || nw != 7 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL post_summary got trig_ptr=%0d last=%0d done_addr=%0d writes=%0d done=%b exp 3 6 6 7 1",
               trig_ptr, last, done_addr, nw, done);
    end
  endtask

  task automatic test_zero_post();
    int nw = 0, done_addr = -1;
    len = 4'd0;
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b1, $urandom, i == 5, 1'b0);
      vectors++; if (obs() !== expv()) begin miscompares++; $display("FAIL zero_model i=%0d got %h exp %h", i, obs(), expv()); end
      if (mem.a_we === 1'b1) begin
        nw++;
        if (done === 1'b1) done_addr = int'(mem.a_addr);
      end
    end
    vectors++;
    if (trig_ptr !== 4'd2 || done_addr != 2 || nw != 3) begin
      miscompares++;
      $display("FAIL zero_summary got trig_ptr=%0d done_addr=%0d writes=%0d exp 2 2 3", trig_ptr, done_addr, nw);
    end
  endtask

  task automatic test_overrun();
    len = 4'd5;
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, $urandom, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    vectors++; if (overrun_err !== 1'b1 || triggered !== 1'b1) begin miscompares++; $display("FAIL ovr_set got ovr=%b trig=%b exp 1 1", overrun_err, triggered); end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, $urandom, 1'b0, 1'b0);
      vectors++; if (obs() !== expv()) begin miscompares++; $display("FAIL ovr_model i=%0d got %h exp %h", i, obs(), expv()); end
    end
    vectors++; if (done !== 1'b1 || overrun_err !== 1'b1) begin miscompares++; $display("FAIL ovr_done got done=%b ovr=%b exp 1 1", done, overrun_err); end
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    vectors++; if (overrun_err !== 1'b0 || armed !== 1'b1) begin miscompares++; $display("FAIL ovr_clear got ovr=%b armed=%b exp 0 1", overrun_err, armed); end
  endtask

  task automatic test_restart_reset();
    int first = -1;
    len = 4'd8;
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, $urandom, i == 0, 1'b0);
    vectors++; if (triggered !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL restart_mid got trig=%b done=%b exp 1 0", triggered, done); end
    step(1'b1, 1'b1, $urandom, 1'b0, 1'b0);
    vectors++; if (obs() !== expv()) begin miscompares++; $display("FAIL restart_arm got %h exp %h", obs(), expv()); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, $urandom, 1'b0, 1'b0);
      vectors++; if (obs() !== expv()) begin miscompares++; $display("FAIL restart_model i=%0d got %h exp %h", i, obs(), expv()); end
      if (mem.a_we === 1'b1 && first < 0) first = int'(mem.a_addr);
    end
    vectors++; if (first != 0 || wrapped !== 1'b0) begin miscompares++; $display("FAIL restart_addr got first=%0d wrapped=%b exp 0 0", first, wrapped); end
    step(1'b0, 1'b1, $urandom, 1'b0, 1'b0);
    do_reset();
    vectors++;
    if ({obs(), mem.a_addr, mem.a_di} !== '0) begin
      miscompares++;
      $display("FAIL midreset_values got %h addr %h di %h expected all zero", obs(), mem.a_addr, mem.a_di);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, $urandom, 1'b1, 1'b0);
      vectors++; if (mem.a_we !== 1'b0 || armed !== 1'b0) begin miscompares++; $display("FAIL idle_ignore got we=%b armed=%b exp 0 0", mem.a_we, armed); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        vectors++; if (obs() !== expv()) begin miscompares++; $display("FAIL rand_reset i=%0d got %h exp %h", i, obs(), expv()); end
      end
      len = 4'($urandom_range(0, 5));
      step($urandom_range(0, 29) == 0, $urandom_range(0, 2) != 0, $urandom,
           $urandom_range(0, 11) == 0, $urandom_range(0, 24) == 0);
      vectors++; if (obs() !== expv()) begin miscompares++; $display("FAIL rand_model i=%0d got %h exp %h", i, obs(), expv()); end
    end
  endtask

  initial begin
    mem.a_overrun = 1'b0;
    test_reset();
    test_pack_order();
    test_wrap();
    test_post_trigger();
    test_zero_post();
    test_overrun();
    test_restart_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
